// File: rtl/bram_pkg.sv
// Shared definitions for the bram built-in self-test controller.
//
// Contents:
//   BRAM_ADDR_W / BRAM_DATA_W : default bram geometry
//   bist_state_e              : controller FSM state encoding (3 bits)
//   bist_pattern()            : march data pattern, pattern(a) = a ^ seed.
//                               Callers truncate the result to their data
//                               width; widths up to 32 bits are supported.
package bram_pkg;

    localparam int BRAM_ADDR_W = 8;
    localparam int BRAM_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    // The address is zero-extended before the XOR, so data wider than the
    // address gets the seed's upper bits unchanged.
    function automatic logic [31:0] bist_pattern(input logic [31:0] addr,
                                                 input logic [31:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/bram_bist_dly.sv
// Expected-data delay line for the bram self-test.
//
// A DEPTH-stage shift register of {valid, data}. Each entry leaves the last
// stage DEPTH clocks after it entered, lining the expected value up with the
// bram read data.
//
// Ports:
//   clk       in   clock, rising edge
//   clr_n     in   synchronous active-low clear of every stage
//   in_valid  in   valid bit of the entry shifted in this cycle
//   in_data   in   expected data shifted in this cycle
//   out_valid out  valid bit of the oldest stage
//   out_data  out  expected data of the oldest stage
module bram_bist_dly #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    localparam int W = DATA_W + 1;

    // Stage 0 occupies the low W bits; the oldest stage sits at the top.
    logic [DEPTH*W-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (!clr_n) begin
                    sr <= '0;
                end else begin
                    sr <= {in_valid, in_data};
                end
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (!clr_n) begin
                    sr <= '0;
                end else begin
                    sr <= {sr[(DEPTH-1)*W-1:0], in_valid, in_data};
                end
            end
        end
    endgenerate

    assign out_valid = sr[DEPTH*W-1];
    assign out_data  = sr[DEPTH*W-2 -: DATA_W];

endmodule

// File: rtl/bram_bist_ctrl.sv
// Built-in self-test initiator for the single-port bram.
//
// On an accepted start it writes pattern(a) to every address, reads every
// address back, compares each returned word against the expected pattern
// and reports pass/fail with a saturating error count.
// Test length from accepted start to done=1 is 2*DEPTH + READ_LAT + 1 clocks.
//
// Optional feature macro: BRAM_BIST_FAIL_CAPTURE_EN
//   When defined, fail_valid/fail_addr/fail_data capture the address and read
//   data of the first mismatch of each test.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   synchronous active-low reset
//   start          in   one-cycle pulse, accepted only when not busy
//   busy           out  test in progress
//   done           out  test complete, held until the next accepted start
//   pass           out  valid with done; 1 when no mismatch was seen
//   err_count      out  mismatching locations, saturating
//   mem_readWrite  out  bram readWrite (1 = write, 0 = read)
//   mem_addr       out  bram addr
//   mem_data       out  bram data
//   mem_out        in   bram out
//   state          out  current FSM state, for observation
//   fail_valid/fail_addr/fail_data  out  first-mismatch capture (macro only)
//
// Handshake: start is a single-cycle request with no acknowledge. It is
// taken in IDLE, or in DONE once busy has dropped; any other start is
// dropped. Reset has priority over start.
module bram_bist_ctrl
    import bram_pkg::*;
#(
    parameter int                ADDR_W   = BRAM_ADDR_W,
    parameter int                DATA_W   = BRAM_DATA_W,
    parameter int                READ_LAT = 1,
    parameter logic [DATA_W-1:0] SEED     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic              mem_readWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_out,
    output bist_state_e       state
`ifdef BRAM_BIST_FAIL_CAPTURE_EN
    ,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
`endif
);

    localparam int DRAIN_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    logic [ADDR_W-1:0]  cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DATA_W-1:0]  cnt_pat;
    logic [DATA_W-1:0]  addr_pat;
    logic               start_acc;

    // High in every cycle a read address is on mem_addr.
    logic               rd_issue;

    logic               dly_valid;
    logic [DATA_W-1:0]  dly_exp;
    logic               mismatch;
    logic [ADDR_W:0]    err_next;

    assign cnt_pat   = DATA_W'(bist_pattern(32'(cnt), 32'(SEED)));
    assign addr_pat  = DATA_W'(bist_pattern(32'(mem_addr), 32'(SEED)));
    assign start_acc = start && !busy && (state == ST_IDLE || state == ST_DONE);

    // The delay line is fed from the registered address, so its output lines
    // up with mem_out READ_LAT clocks after the address reaches the bram.
    bram_bist_dly #(
        .DATA_W (DATA_W),
        .DEPTH  (READ_LAT)
    ) u_dly (
        .clk       (clk),
        .clr_n     (rst_n),
        .in_valid  (rd_issue),
        .in_data   (addr_pat),
        .out_valid (dly_valid),
        .out_data  (dly_exp)
    );

    assign mismatch = dly_valid && (mem_out != dly_exp);

    always_comb begin
        err_next = err_count;
        if (mismatch && !(&err_count)) begin
            err_next = err_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            mem_readWrite <= 1'b0;
            mem_addr      <= '0;
            mem_data      <= '0;
            rd_issue      <= 1'b0;
        end else begin
            err_count <= err_next;
            rd_issue  <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    mem_readWrite <= 1'b0;
                    if (start_acc) begin
                        state     <= ST_WRITE;
                        cnt       <= '0;
                        err_count <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end else if (state == ST_DONE) begin
                        // The last compare retires on this edge, so pass
                        // is taken from the updated count.
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_next == '0);
                    end
                end
                ST_WRITE: begin
                    mem_readWrite <= 1'b1;
                    mem_addr      <= cnt;
                    mem_data      <= cnt_pat;
                    cnt           <= cnt + 1'b1;
                    // cnt wraps to 0 on the same edge, ready for the reads.
                    if (&cnt) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    mem_readWrite <= 1'b0;
                    mem_addr      <= cnt;
                    mem_data      <= '0;
                    rd_issue      <= 1'b1;
                    cnt           <= cnt + 1'b1;
                    if (&cnt) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    mem_readWrite <= 1'b0;
                    mem_data      <= '0;
                    drain_cnt     <= drain_cnt + 1'b1;
                    if (drain_cnt == DRAIN_W'(READ_LAT - 1)) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    mem_readWrite <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRAM_BIST_FAIL_CAPTURE_EN
    // Reads come back in address order, so counting compares gives the
    // address of the word being checked.
    logic [ADDR_W-1:0] cmp_idx;

    always_ff @(posedge clk) begin
        if (!rst_n || start_acc) begin
            cmp_idx    <= '0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
        end else if (dly_valid) begin
            cmp_idx <= cmp_idx + 1'b1;
            if (mismatch && !fail_valid) begin
                fail_valid <= 1'b1;
                fail_addr  <= cmp_idx;
                fail_data  <= mem_out;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bram_bist_ctrl.sv
// Bench for bram_bist_ctrl: two instances (READ_LAT=1/SEED=0 and
// READ_LAT=2/SEED=A5), each driving a behavioural bram with optional
// stuck-at-0 on data bit 0. A timeline model derived from the test length
// and march order predicts every output on every cycle.
module tb_bram_bist_ctrl;
    import bram_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int D  = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    start = 2'b00;
    logic          busy [2];
    logic          done [2];
    logic          pass [2];
    logic [AW:0]   err  [2];
    logic          rw   [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata[2];
    logic [DW-1:0] rdata[2];
    bist_state_e   st   [2];
    bit            stuck[2];
`ifdef BRAM_BIST_FAIL_CAPTURE_EN
    logic          fv   [2];
    logic [AW-1:0] fa   [2];
    logic [DW-1:0] fd   [2];
`endif

    bram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .SEED(8'h00)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err[0]), .mem_readWrite(rw[0]), .mem_addr(addr[0]),
        .mem_data(wdata[0]), .mem_out(rdata[0]), .state(st[0])
`ifdef BRAM_BIST_FAIL_CAPTURE_EN
        , .fail_valid(fv[0]), .fail_addr(fa[0]), .fail_data(fd[0])
`endif
    );

    bram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .SEED(8'hA5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err[1]), .mem_readWrite(rw[1]), .mem_addr(addr[1]),
        .mem_data(wdata[1]), .mem_out(rdata[1]), .state(st[1])
`ifdef BRAM_BIST_FAIL_CAPTURE_EN
        , .fail_valid(fv[1]), .fail_addr(fa[1]), .fail_data(fd[1])
`endif
    );

    // Behavioural brams: out valid L clocks after the address is presented.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        localparam int L = (g == 0) ? 1 : 2;
        logic [DW-1:0] mem  [D];
        logic [DW-1:0] pipe [L];
        always @(posedge clk) begin
            if (rw[g]) mem[addr[g]] <= wdata[g];
            pipe[0] <= mem[addr[g]];
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign rdata[g] = stuck[g] ? (pipe[L-1] & 8'hFE) : pipe[L-1];
    end

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];

    bit active [2] = '{1'b0, 1'b0};
    int t      [2] = '{0, 0};
    int hold   [2] = '{0, 0};
    bit stuck_m[2] = '{1'b0, 1'b0};

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int seed_of(input int i);
        return (i == 0) ? 'h00 : 'hA5;
    endfunction

    function automatic int tdone(input int i);
        return 2 * D + lat_of(i) + 1;
    endfunction

    function automatic bit is_bad(input int i, input int a);
        return stuck_m[i] && (((a ^ seed_of(i)) & 1) == 1);
    endfunction

    // Mismatching locations among addresses 0 .. lim-1.
    function automatic int bad_before(input int i, input int lim);
        int n = 0;
        for (int a = 0; a < D && a < lim; a++) if (is_bad(i, a)) n++;
        return n;
    endfunction

    function automatic int first_bad(input int i);
        for (int a = 0; a < D; a++) if (is_bad(i, a)) return a;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                active[i] <= 1'b0;
                t[i]      <= 0;
                hold[i]   <= 0;
                if (i == 0) exp_q0.delete(); else exp_q1.delete();
            end else if (start[i] && !(active[i] && t[i] < tdone(i))) begin
                hold[i]    <= active[i] ? D - 1 : 0;
                active[i]  <= 1'b1;
                t[i]       <= 0;
                stuck_m[i] <= stuck[i];
                if (i == 0) exp_q0.delete(); else exp_q1.delete();
                for (int a = 0; a < D; a++) begin
                    if (i == 0) exp_q0.push_back(8'(a ^ seed_of(i)));
                    else        exp_q1.push_back(8'(a ^ seed_of(i)));
                end
            end else if (active[i]) begin
                t[i] <= t[i] + 1;
            end
        end
    end

    task automatic compare_dut(input int i);
        int tt, tt_done, lat, lim, fb, exp_err, exp_addr;
        bit exp_rw, exp_busy, exp_done;
        bist_state_e exp_st;
        logic [31:0] e;
        string p;
        p = $sformatf("d%0d_", i);
        if (!active[i]) begin
            exp_st = ST_IDLE; exp_busy = 0; exp_done = 0; exp_err = 0;
            exp_rw = 0; exp_addr = 0; lim = 0;
        end else begin
            tt = t[i]; tt_done = tdone(i); lat = lat_of(i);
            exp_st   = (tt < D) ? ST_WRITE : (tt < 2*D) ? ST_READ :
                       (tt < 2*D + lat) ? ST_DRAIN : ST_DONE;
            exp_busy = (tt < tt_done);
            exp_done = (tt >= tt_done);
            lim      = tt - D - 1 - lat;
            exp_err  = bad_before(i, lim);
            exp_rw   = (tt >= 1 && tt <= D);
            exp_addr = (tt == 0) ? hold[i] : (tt <= D) ? tt - 1 :
                       (tt <= 2*D) ? tt - D - 1 : D - 1;
        end
        check({p, "state"}, 32'(st[i]), 32'(exp_st));
        check({p, "busy"}, 32'(busy[i]), 32'(exp_busy));
        check({p, "done"}, 32'(done[i]), 32'(exp_done));
        check({p, "pass"}, 32'(pass[i]), 32'(exp_done && exp_err == 0));
        check({p, "err_count"}, 32'(err[i]), exp_err);
        check({p, "readWrite"}, 32'(rw[i]), 32'(exp_rw));
        check({p, "addr"}, 32'(addr[i]), exp_addr);
        if (exp_rw) begin
            e = 32'hDEAD;
            if (i == 0 && exp_q0.size() > 0) e = 32'(exp_q0.pop_front());
            if (i == 1 && exp_q1.size() > 0) e = 32'(exp_q1.pop_front());
            check({p, "wdata"}, 32'(wdata[i]), e);
        end else begin
            check({p, "data_idle"}, 32'(wdata[i]), 0);
        end
`ifdef BRAM_BIST_FAIL_CAPTURE_EN
        fb = first_bad(i);
        if (active[i] && fb >= 0 && fb < lim) begin
            check({p, "fail_valid"}, 32'(fv[i]), 1);
            check({p, "fail_addr"}, 32'(fa[i]), fb);
            check({p, "fail_data"}, 32'(fd[i]), (fb ^ seed_of(i)) & 'hFE);
        end else begin
            check({p, "fail_valid"}, 32'(fv[i]), 0);
        end
`else
        fb = 0;
`endif
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) compare_dut(i);
        end
    end

    // ---------------- driver tasks ----------------
    logic [DW-1:0] seen_data = '0;
    bit            seen      = 1'b0;

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    // Starts a test on instance i and counts clocks until done (bounded).
    // repulse_at > 0 re-pulses start at that cycle; rst_at > 0 applies reset
    // (with a simultaneous start) at that cycle and returns after one clock.
    task automatic run_test(input int i, input int repulse_at, input int rst_at, output int cycles);
        pulse_start(i);
        cycles = 0;
        while (!done[i] && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            start[i] = (cycles == repulse_at);
            if (i == 1 && rw[1] && addr[1] == 8'h10) begin
                seen      = 1'b1;
                seen_data = wdata[1];
            end
            if (cycles == rst_at) begin
                rst_n    = 1'b0;
                start[i] = 1'b1;
                @(negedge clk);
                check("rst_mid_state", 32'(st[i]), 32'(ST_IDLE));
                check("rst_mid_busy", 32'(busy[i]), 0);
                check("rst_mid_done", 32'(done[i]), 0);
                check("rst_mid_readWrite", 32'(rw[i]), 0);
                rst_n    = 1'b1;
                start[i] = 1'b0;
                return;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        stuck[0] = 1'b0;
        stuck[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", 32'(busy[0]), 0);
        check("reset_done", 32'(done[0]), 0);
        check("reset_pass", 32'(pass[0]), 0);
        check("reset_err", 32'(err[0]), 0);
        check("reset_readWrite", 32'(rw[0]), 0);
        check("reset_addr", 32'(addr[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good bram, READ_LAT=1, SEED=0.
        run_test(0, 0, 0, cyc);
        check("t1_latency", cyc, 514);
        check("t1_pass", 32'(pass[0]), 1);
        check("t1_err", 32'(err[0]), 0);

        // Bit 0 stuck at 0, with a start re-pulse while busy.
        stuck[0] = 1'b1;
        run_test(0, 100, 0, cyc);
        check("t2_latency", cyc, 514);
        check("t2_err", 32'(err[0]), 128);
        check("t2_pass", 32'(pass[0]), 0);
`ifdef BRAM_BIST_FAIL_CAPTURE_EN
        check("t2_fail_addr", 32'(fa[0]), 32'h01);
        check("t2_fail_data", 32'(fd[0]), 32'h00);
`endif
        stuck[0] = 1'b0;

        // READ_LAT=2, SEED=A5, good bram.
        seen = 1'b0;
        run_test(1, 0, 0, cyc);
        check("t3_latency", cyc, 515);
        check("t3_seen_addr10", 32'(seen), 1);
        check("t3_data_addr10", 32'(seen_data), 32'hB5);
        check("t3_pass", 32'(pass[1]), 1);
        check("t3_err", 32'(err[1]), 0);

        // Reset during the read phase, then a fresh complete test.
        run_test(0, 0, 300, cyc);
        @(negedge clk);
        run_test(0, 0, 0, cyc);
        check("t4_latency", cyc, 514);
        check("t4_pass", 32'(pass[0]), 1);
        check("t4_err", 32'(err[0]), 0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
